// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bus bundle for the multi-port register file.
//
// Signals:
//   rs, rt     read addresses for ports A and B
//   rd         write address
//   writedata  write data
//   regwrite   write enable
//   clr_req    request a sequenced clear of every entry
//   A, B       combinational read data for rs / rt
//   busy       high while the clear sequence runs
//   dbg_state  current FSM state (0 = IDLE, 1 = CLEAR), for checkers
//
// Handshake: there is no valid/ready pair. regwrite and clr_req are
// qualifiers sampled on every rising clock edge. A write is taken only when
// busy is low, and a write presented while busy is high is dropped, not
// held. clr_req is ignored while busy is high. The master watches busy to
// learn when writes will be accepted again.
//
// Modports:
//   master  drives the addresses, data and requests (bench or CPU side)
//   slave   the register file itself
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [WIDTH-1:0]  writedata;
  logic              regwrite;
  logic              clr_req;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              busy;
  logic              dbg_state;

  modport master (
    output rs, rt, rd, writedata, regwrite, clr_req,
    input  A, B, busy, dbg_state
  );

  modport slave (
    input  rs, rt, rd, writedata, regwrite, clr_req,
    output A, B, busy, dbg_state
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- two-read / one-write register file with a sequenced clear.
//
// Ports:
//   clk    single clock; all state updates happen on the rising edge
//   rst_n  asynchronous active-low reset; zeroes every entry at once
//   bus    regfile_mp_if slave modport (rs, rt, rd, writedata, regwrite,
//          clr_req in; A, B, busy, dbg_state out)
//
// The read ports are combinational. In IDLE a write to the address being
// read is bypassed to that port in the same cycle. clr_req starts a clear
// that zeroes one entry per cycle, from 0 up to DEPTH-1. During the clear,
// writes are dropped and bypass is off.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              busy_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              rd_is_zero;
  logic              wr_en;

  // With ZERO_REG set, entry 0 is never written. Its storage then holds 0
  // because reset and clear only ever write 0 into it.
  assign rd_is_zero = (ZERO_REG != 0) && (bus.rd == '0);
  assign wr_en      = (state == IDLE) && bus.regwrite && !rd_is_zero;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        // idx wraps naturally to 0 on the last entry.
        idx_nxt = idx + 1'b1;
        if (idx == '1) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      busy_q <= (state_nxt == CLEAR);
    end
  end

  // Storage. The clear takes priority over writes. wr_en is already gated
  // to IDLE, so this ordering only makes the intent explicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_en) begin
      mem[bus.rd] <= bus.writedata;
    end
  end

  // Read ports: storage, overridden by the same-cycle write (bypass), then
  // forced to 0 for the zero register and while reset is held.
  always_comb begin
    bus.A = mem[bus.rs];
    if (wr_en && (bus.rd == bus.rs)) begin
      bus.A = bus.writedata;
    end
    if (!rst_n || ((ZERO_REG != 0) && (bus.rs == '0))) begin
      bus.A = '0;
    end
  end

  always_comb begin
    bus.B = mem[bus.rt];
    if (wr_en && (bus.rd == bus.rt)) begin
      bus.B = bus.writedata;
    end
    if (!rst_n || ((ZERO_REG != 0) && (bus.rt == '0))) begin
      bus.B = '0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.dbg_state = (state == CLEAR);
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp.
// Two instances: the default 32x32 file, and an 8-bit x 8-entry file for
// width truncation and a short clear.
module tb_regfile_mp;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(32), .ADDR_W(5)) bus ();
  regfile_mp_if #(.WIDTH(8),  .ADDR_W(3)) bus8 ();

  regfile_mp #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_mp #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] bsy);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(bsy);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty got=%h", tag, got);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  // Waits for the outputs to settle, then compares A, B and busy.
  task automatic sample(input string tag);
    #2;
    pop_chk({tag, ".A"}, bus.A);
    pop_chk({tag, ".B"}, bus.B);
    pop_chk({tag, ".busy"}, 32'(bus.busy));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] wd, input logic we, input logic clr);
    bus.rs        = rs;
    bus.rt        = rt;
    bus.rd        = rd;
    bus.writedata = wd;
    bus.regwrite  = we;
    bus.clr_req   = clr;
  endtask

  // Reference read in IDLE: zero register, same-cycle bypass, then storage.
  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && (rd == a)) return wd;
    return ref_mem[a];
  endfunction

  // One IDLE cycle: drive, predict, compare, clock, update the model.
  task automatic step_chk(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] wd, input logic we);
    drive(rs, rt, rd, wd, we, 1'b0);
    push_exp(mread(rs, we, rd, wd), mread(rt, we, rd, wd), 32'd0);
    sample(tag);
    tick();
    if (we && (rd != 5'd0)) ref_mem[rd] = wd;
  endtask

  // Counts the cycles busy stays high. Call this one cycle after the clr_req edge.
  task automatic count_busy(input int which, output int n);
    n = 0;
    #2;
    while (((which == 0) ? bus.busy : bus8.busy) && (n < 200)) begin
      n++;
      @(posedge clk);
      #3;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  ra, rb, rw;
    logic [31:0] wd;
    logic        we;
    logic [8:0]  wide;
    int          n;

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    bus8.rs = '0; bus8.rt = '0; bus8.rd = '0;
    bus8.writedata = '0; bus8.regwrite = 1'b0; bus8.clr_req = 1'b0;

    // Reset holds the outputs at 0, even with a write and bypass present.
    rst_n = 1'b0;
    drive(5'd2, 5'd2, 5'd2, 32'd5, 1'b1, 1'b0);
    push_exp(32'd0, 32'd0, 32'd0);
    sample("rst");
    tick();
    drive(5'd2, 5'd2, 5'd0, 32'd0, 1'b0, 1'b0);
    push_exp(32'd0, 32'd0, 32'd0);
    sample("rst_wr_ignored");
    rst_n = 1'b1;

    // Basic reads after reset
    drive(5'd0, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
    push_exp(32'd0, 32'd0, 32'd0);
    sample("post_rst");
    tick();

    // Bypass, storage, zero register
    step_chk("bypass", 5'd2, 5'd2, 5'd2, 32'd27, 1'b1);
    step_chk("stored", 5'd2, 5'd1, 5'd0, 32'd0, 1'b0);
    step_chk("zero_wr", 5'd0, 5'd2, 5'd0, 32'hDEADBEEF, 1'b1);
    step_chk("zero_rd", 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);

    // Random traffic. Every fourth cycle targets rs, and every third sets rt = rs.
    for (int i = 0; i < 24; i++) begin
      ra = 5'($urandom_range(0, 31));
      rb = ((i % 3) == 0) ? ra : 5'($urandom_range(0, 31));
      rw = ((i % 4) == 0) ? ra : 5'($urandom_range(0, 31));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      step_chk("rnd", ra, rb, rw, wd, we);
    end

    // Fill 1..31 with their own index
    for (int i = 1; i < 32; i++) begin
      step_chk("fill", 5'(i), 5'(i - 1), 5'(i), 32'(i), 1'b1);
    end

    // Sequenced clear: 32 busy cycles, one entry zeroed per edge.
    drive(5'd31, 5'd5, 5'd0, 32'd0, 1'b0, 1'b1);
    push_exp(32'd31, 32'd5, 32'd0);
    sample("clr_req");
    tick();
    for (int k = 0; k < 32; k++) begin
      // A write at k=2 must be dropped with no bypass. A clr_req at k=10 must be ignored.
      drive(5'd31, 5'd5, 5'd5, 32'd99, (k == 2), (k == 10));
      push_exp(ref_mem[31], ref_mem[5], 32'd1);
      sample("clearing");
      tick();
      ref_mem[k] = 32'd0;
    end
    drive(5'd31, 5'd5, 5'd0, 32'd0, 1'b0, 1'b0);
    push_exp(32'd0, 32'd0, 32'd0);
    sample("clr_done");
    tick();

    // Write and clr_req in the same cycle: the write lands, then the clear starts.
    drive(5'd30, 5'd30, 5'd30, 32'd77, 1'b1, 1'b1);
    push_exp(32'd77, 32'd77, 32'd0);
    sample("wr_clr");
    tick();
    ref_mem[30] = 32'd77;
    for (int k = 0; k < 10; k++) begin
      drive(5'd30, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0);
      push_exp(ref_mem[30], ref_mem[3], 32'd1);
      sample("clr2");
      tick();
      ref_mem[k] = 32'd0;
    end
    // Clear cycle 10: assert reset asynchronously, between clock edges.
    push_exp(32'd77, 32'd0, 32'd1);
    sample("pre_abort");
    #1;
    rst_n = 1'b0;
    push_exp(32'd0, 32'd0, 32'd0);
    sample("async_abort");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    tick();
    for (int i = 0; i < 32; i++) begin
      step_chk("post_abort", 5'(i), 5'(31 - i), 5'd0, 32'd0, 1'b0);
    end

    // A new clear after the abort runs the full 32 cycles.
    drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    bus.clr_req = 1'b0;
    count_busy(0, n);
    check("clr_len32", 32'(n), 32'd32);

    // Narrow instance: write data truncates to 8 bits, and a clear takes 8 cycles.
    tick();
    wide = 9'h1FF;
    bus8.rd = 3'd7; bus8.rs = 3'd7; bus8.rt = 3'd0;
    bus8.writedata = wide[7:0];
    bus8.regwrite = 1'b1;
    #2;
    check("w8_bypass", 32'(bus8.A), 32'h0000_00FF);
    tick();
    bus8.regwrite = 1'b0;
    #2;
    check("w8_stored", 32'(bus8.A), 32'h0000_00FF);
    check("w8_zero", 32'(bus8.B), 32'd0);
    tick();
    bus8.clr_req = 1'b1;
    tick();
    bus8.clr_req = 1'b0;
    count_busy(1, n);
    check("clr_len8", 32'(n), 32'd8);
    check("w8_cleared", 32'(bus8.A), 32'd0);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stops the run if the stimulus stalls.
  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32: data width of each register.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rs  input  ADDR_W  read address, port A.
REQ-007 rt  input  ADDR_W  read address, port B.
REQ-008 rd  input  ADDR_W  write address.
REQ-009 writedata  input  WIDTH  write data.
REQ-010 regwrite  input  1  write enable.
REQ-011 clr_req  input  1  request a sequenced clear of all entries.
REQ-012 A  output  WIDTH  read data for rs.
REQ-013 B  output  WIDTH  read data for rt.
REQ-014 busy  output  1  high while the clear sequence runs.

Function
REQ-015 Writes: on a rising edge with regwrite=1 in state IDLE, entry rd SHALL take writedata.
REQ-016 Zero register: with ZERO_REG=1, writes to rd=0 SHALL be discarded, and reads of address 0 SHALL return 0.
REQ-017 Reads: A and B SHALL be combinational from rs and rt, with zero cycles of latency.
REQ-018 Bypass: in IDLE with regwrite=1 and rd equal to the read address (and that address not the zero register when ZERO_REG=1), the port SHALL return writedata in the same cycle.
REQ-019 Dual read: rs=rt SHALL return identical data on A and B, including the bypass case.
REQ-020 FSM states SHALL be IDLE and CLEAR; idx is an ADDR_W-bit counter.
REQ-021 Transition IDLE->CLEAR: on an edge with clr_req=1, and idx SHALL load 0.
REQ-022 CLEAR operation: each edge SHALL write 0 to entry idx and increment idx, so one entry clears per cycle.
REQ-023 Transition CLEAR->IDLE: on the edge that clears idx=DEPTH-1; idx wraps to 0, and a full clear takes exactly DEPTH cycles.
REQ-024 busy SHALL be 1 exactly while the state is CLEAR; it is registered and deasserts on the cycle after the last entry clears.
REQ-025 During CLEAR: regwrite SHALL be ignored (the write is dropped, not queued), bypass SHALL be disabled, and reads SHALL return stored contents, with already-cleared entries reading 0.
REQ-026 clr_req asserted during CLEAR SHALL be ignored, with no restart and no extension.
REQ-027 Simultaneous clr_req=1 and regwrite=1 in IDLE: the write SHALL complete on that edge, and CLEAR SHALL begin on the following cycle.
REQ-028 A non-power-of-two usable depth is not supported; all DEPTH entries SHALL exist.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, set all entries to 0, state to IDLE, idx to 0 and busy to 0.
REQ-030 While rst_n=0: A=B=0 and writes are ignored.
REQ-031 Reset asserted mid-CLEAR SHALL abort the sequence; after release the block is IDLE and all entries read 0.
REQ-032 Deassertion of rst_n SHALL be the only reset exit; the first write is accepted on the first rising edge with rst_n=1.

Verification
REQ-033 Reset, then rs=0, rt=1, rd=2, regwrite=0 -> A=0, B=0, busy=0.
REQ-034 rd=2, writedata=27, regwrite=1 with rs=2 in the same cycle -> A=27 via bypass; after the edge with regwrite=0 -> A=27 from storage.
REQ-035 ZERO_REG=1: rd=0, writedata=0xDEADBEEF, regwrite=1, rs=0 -> A=0 both in the write cycle and after the edge.
REQ-036 Fill entries 1..31 with their own index, pulse clr_req for one cycle -> busy high for exactly 32 cycles; rs=31 reads 31 until the 32nd clear cycle, then 0; regwrite to rd=5 issued during busy leaves entry 5 at 0.
REQ-037 Assert rst_n=0 asynchronously at clear cycle 10 -> busy drops without a clock edge; after release every address reads 0 and clr_req starts a new 32-cycle clear.
REQ-038 WIDTH=8, ADDR_W=3: writedata=0x1FF to rd=7 -> entry 7 holds 0xFF (truncated), and a clear takes 8 cycles.
